// File: rtl/key_encoder_if.sv
// Stream bundle for key_encoder: a request-vector input stream and an encoded-beat output stream.
// Both streams: a beat transfers on a rising clk edge where valid && ready; the sender holds valid and its payload until then.
interface key_encoder_if #(
  parameter int NR_IN   = 8,
  parameter int IDX_LEN = 3
);
  logic               in_valid;
  logic               in_ready;
  logic [NR_IN-1:0]   in_data;
  logic               out_valid;
  logic               out_ready;
  logic [IDX_LEN-1:0] out_idx;
  logic               out_none;
  logic               out_last;
  logic [IDX_LEN-1:0] out_seq;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_idx, out_none, out_last, out_seq
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_idx, out_none, out_last, out_seq
  );
endinterface

// File: rtl/key_encoder.sv
// Captures a key request vector and reports its set bits one beat at a time, highest index first.
// An all-zero vector produces a single beat flagged with out_none.
module key_encoder #(
  parameter int NR_IN   = 8,
  parameter int IDX_LEN = 3
) (
  input  logic          clk,
  input  logic          rst,
  key_encoder_if.slave  bus,
  output logic          dbg_state
);

  typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_t;

  state_t           state;
  logic [NR_IN-1:0] pending;
  logic [NR_IN-1:0] nxt_pending;

  function automatic logic [IDX_LEN-1:0] msb_idx(input logic [NR_IN-1:0] v);
    msb_idx = '0;
    for (int i = 0; i < NR_IN; i++) begin
      if (v[i]) msb_idx = IDX_LEN'(i);
    end
  endfunction

  function automatic logic at_most_one(input logic [NR_IN-1:0] v);
    return (v & (v - NR_IN'(1))) == '0;
  endfunction

  // out_idx always names the highest set bit of pending, so this is pending after the current beat.
  always_comb nxt_pending = pending & ~(NR_IN'(1) << bus.out_idx);

  assign bus.in_ready = (state == IDLE);
  assign dbg_state    = logic'(state);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      pending       <= '0;
      bus.out_seq   <= '0;
      bus.out_valid <= 1'b0;
      bus.out_idx   <= '0;
      bus.out_none  <= 1'b0;
      bus.out_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            state         <= DRAIN;
            pending       <= bus.in_data;
            bus.out_seq   <= '0;
            bus.out_valid <= 1'b1;
            bus.out_idx   <= msb_idx(bus.in_data);
            bus.out_none  <= (bus.in_data == '0);
            bus.out_last  <= at_most_one(bus.in_data);
          end
        end
        DRAIN: begin
          if (bus.out_valid && bus.out_ready) begin
            if (bus.out_last) begin
              // Final beat taken: outputs fall back to their idle values.
              state         <= IDLE;
              pending       <= '0;
              bus.out_seq   <= '0;
              bus.out_valid <= 1'b0;
              bus.out_idx   <= '0;
              bus.out_none  <= 1'b0;
              bus.out_last  <= 1'b0;
            end else begin
              pending       <= nxt_pending;
              bus.out_seq   <= bus.out_seq + IDX_LEN'(1);
              bus.out_idx   <= msb_idx(nxt_pending);
              bus.out_none  <= 1'b0;
              bus.out_last  <= at_most_one(nxt_pending);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_encoder.sv
// Self-checking bench for key_encoder: directed scenarios plus randomized vectors against a
// bit-list reference model of the expected beat sequence.
module tb_key_encoder;
  localparam int NR_IN   = 8;
  localparam int IDX_LEN = 3;
  localparam int W       = 2 * IDX_LEN + 2;

  logic clk;
  logic rst;
  logic dbg_state;

  key_encoder_if #(.NR_IN(NR_IN), .IDX_LEN(IDX_LEN)) bus ();

  key_encoder #(.NR_IN(NR_IN), .IDX_LEN(IDX_LEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // scoreboard: {idx, none, last, seq}
  logic [W-1:0] exp_q[$];

  function automatic logic [W-1:0] act_beat();
    return {bus.out_idx, bus.out_none, bus.out_last, bus.out_seq};
  endfunction

  // Reference model: list the set bits from the top down; an empty vector is one "none" beat.
  task automatic model_vector(input logic [NR_IN-1:0] v);
    int total;
    int k;
    logic [IDX_LEN-1:0] idx_v;
    logic [IDX_LEN-1:0] seq_v;
    total = $countones(v);
    if (total == 0) begin
      exp_q.push_back({{IDX_LEN{1'b0}}, 1'b1, 1'b1, {IDX_LEN{1'b0}}});
    end else begin
      k = 0;
      for (int i = NR_IN - 1; i >= 0; i--) begin
        if (v[i]) begin
          idx_v = IDX_LEN'(i);
          seq_v = IDX_LEN'(k);
          exp_q.push_back({idx_v, 1'b0, (k == total - 1), seq_v});
          k++;
        end
      end
    end
  endtask

  // Offers v, then drains all beats. stall forces out_ready low for the first beats;
  // after that out_ready is high with probability ready_pct. hold keeps in_valid high during DRAIN.
  task automatic drive_vector(input logic [NR_IN-1:0] v, input int ready_pct,
                              input bit hold, input int stall, input string tag);
    int cycles;
    int nbeats;
    bit rdy;
    model_vector(v);
    nbeats = exp_q.size();
    @(negedge clk);
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s in_ready_before_capture: got %b want 1", tag, bus.in_ready);
    end
    bus.in_valid  = 1'b1;
    bus.in_data   = v;
    bus.out_ready = 1'b0;
    @(negedge clk);
    if (!hold) bus.in_valid = 1'b0;
    else bus.in_data = NR_IN'($urandom);
    cycles = 0;
    while (exp_q.size() > 0 && cycles < 200) begin
      n_cmp++;
      if (bus.out_valid !== 1'b1) begin
        n_err++;
        $display("FAIL %s out_valid: got %b want 1 (cycle %0d)", tag, bus.out_valid, cycles);
      end
      n_cmp++;
      if (act_beat() !== exp_q[0]) begin
        n_err++;
        $display("FAIL %s beat: got idx=%0d none=%b last=%b seq=%0d want idx=%0d none=%b last=%b seq=%0d",
                 tag, bus.out_idx, bus.out_none, bus.out_last, bus.out_seq,
                 exp_q[0][W-1 -: IDX_LEN], exp_q[0][IDX_LEN+1], exp_q[0][IDX_LEN], exp_q[0][IDX_LEN-1:0]);
      end
      if (hold) begin
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin
          n_err++;
          $display("FAIL %s in_ready_during_drain: got %b want 0", tag, bus.in_ready);
        end
      end
      rdy = (cycles >= stall) && ($urandom_range(0, 99) < ready_pct);
      bus.out_ready = rdy;
      @(negedge clk);
      if (rdy) void'(exp_q.pop_front());
      cycles++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL %s timeout: %0d beats outstanding want 0", tag, exp_q.size());
      exp_q.delete();
    end
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s idle_after_last: got out_valid=%b in_ready=%b want 0 1",
               tag, bus.out_valid, bus.in_ready);
    end
    if (ready_pct == 100 && stall == 0) begin
      n_cmp++;
      if (cycles != nbeats) begin
        n_err++;
        $display("FAIL %s drain_cycles: got %0d want %0d", tag, cycles, nbeats);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hA5;
    bus.out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (bus.out_valid !== 1'b0 || act_beat() !== '0 || dbg_state !== 1'b0) begin
        n_err++;
        $display("FAIL reset_hold: got valid=%b beat=%h state=%b want 0 00 0",
                 bus.out_valid, act_beat(), dbg_state);
      end
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: got in_ready=%b out_valid=%b want 1 0", bus.in_ready, bus.out_valid);
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_basic();
    drive_vector(8'b1010_0100, 100, 1'b0, 0, "basic");
  endtask

  task automatic test_zero();
    drive_vector(8'h00, 100, 1'b0, 0, "zero");
  endtask

  task automatic test_backpressure();
    drive_vector(8'h81, 100, 1'b0, 4, "backpressure");
  endtask

  task automatic test_full();
    drive_vector(8'hFF, 100, 1'b1, 0, "full");
  endtask

  task automatic test_reset_mid_op();
    model_vector(8'hF0);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hF0;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid_op_async: got out_valid=%b in_ready=%b want 0 1", bus.out_valid, bus.in_ready);
    end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      n_cmp++;
      if (bus.out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL reset_mid_op_no_beats: got out_valid=%b want 0", bus.out_valid);
      end
    end
    bus.out_ready = 1'b0;
    drive_vector(8'h01, 100, 1'b0, 0, "after_reset");
  endtask

  task automatic test_random();
    logic [NR_IN-1:0] v;
    for (int n = 0; n < 40; n++) begin
      v = NR_IN'($urandom);
      if (n % 8 == 3) v = '0;
      drive_vector(v, $urandom_range(30, 100), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 2), "random");
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 6; n++) drive_vector(NR_IN'($urandom), 100, 1'b0, 0, "back_to_back");
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    #2;
    test_reset();
    test_basic();
    test_zero();
    test_backpressure();
    test_full();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/key_encoder.md
KEY_ENCODER -- requirements
Module: key_encoder

Interface
REQ-001 SHALL have parameter NR_IN, default 8: width of the request vector.
REQ-002 SHALL have parameter IDX_LEN, default 3: index width; NR_IN SHALL equal 2**IDX_LEN.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  request vector offered.
REQ-006 SHALL have port in_ready  output  1  block accepts a vector this cycle.
REQ-007 SHALL have port in_data  input  NR_IN  request vector; bit n set = key n asserted.
REQ-008 SHALL have port out_valid  output  1  encoded beat available.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the beat.
REQ-010 SHALL have port out_idx  output  IDX_LEN  index of the bit being reported.
REQ-011 SHALL have port out_none  output  1  captured vector was all-zero.
REQ-012 SHALL have port out_last  output  1  final beat for the captured vector.
REQ-013 SHALL have port out_seq  output  IDX_LEN  beat ordinal within the current vector, starting at 0.

Function
REQ-014 SHALL implement two states: IDLE and DRAIN.
REQ-015 in_ready SHALL be 1 exactly when state is IDLE; it SHALL be combinational from state only.
REQ-016 In IDLE, in_valid&&in_ready SHALL capture in_data into the pending register, clear out_seq, and enter DRAIN on that edge.
REQ-017 In DRAIN, out_valid SHALL be 1 from the cycle after capture; first-beat latency is therefore 1 cycle.
REQ-018 out_idx SHALL be the index of the highest set bit of pending (MSB priority).
REQ-019 out_last SHALL be 1 when pending has at most one set bit.
REQ-020 When pending is zero in DRAIN, the block SHALL emit exactly one beat with out_none=1, out_idx=0, out_last=1.
REQ-021 On out_valid&&out_ready, the reported bit SHALL be cleared in pending and out_seq incremented by 1.
REQ-022 On out_valid&&out_ready with out_last=1, the state SHALL return to IDLE, and out_valid SHALL be 0 in the next cycle.
REQ-023 While out_valid=1 and out_ready=0, out_idx, out_none, out_last and out_seq SHALL hold stable.
REQ-024 in_valid during DRAIN SHALL be ignored, because in_ready=0; the producer holds its data.
REQ-025 Between consecutive vectors there SHALL be exactly one IDLE cycle, so throughput is popcount(v)+1 cycles per vector when v is nonzero.
REQ-026 out_seq SHALL reach at most NR_IN-1; for an all-ones vector it SHALL count 0..NR_IN-1 with no wrap inside a vector.
REQ-027 out_none SHALL be 0 on every beat of a nonzero vector.
REQ-028 out_* values SHALL be meaningless when out_valid=0, but driven to their reset values in IDLE.

Reset
REQ-029 rst=0 SHALL immediately, without waiting for clk, force state=IDLE, pending=0, out_seq=0, out_valid=0, out_idx=0, out_none=0, out_last=0.
REQ-030 A reset asserted mid-DRAIN SHALL abandon the vector, and no further beats of that vector SHALL appear after rst returns to 1.
REQ-031 After release of rst, in_ready SHALL be 1 and the first capture SHALL occur on the first rising clk edge with in_valid=1.

Verification
REQ-032 Reset: hold rst=0 for 3 cycles with in_valid=1 -> out_valid=0, no capture; after release, in_ready=1.
REQ-033 Basic: in_data=8'b1010_0100, out_ready=1 -> beats idx 7,5,2 on consecutive cycles; seq 0,1,2; last only on idx 2; then in_ready=1.
REQ-034 Zero: in_data=8'h00 -> single beat idx=0, none=1, last=1, seq=0; DRAIN lasts 1 cycle.
REQ-035 Backpressure: in_data=8'h81, out_ready=0 for 4 cycles -> idx=7, last=0 stable; release -> idx 7 then idx 0 with last=1.
REQ-036 Full vector: in_data=8'hFF, out_ready=1 -> 8 beats idx 7..0, seq 0..7, last on beat 8; in_valid held high during DRAIN is not captured early.
REQ-037 Reset mid-op: in_data=8'hF0, drop rst after 2 beats -> out_valid=0 asynchronously; after release, a new capture of 8'h01 yields one beat idx=0, seq=0, last=1.
